// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle control sequencer for a single-issue RV32I core.
// Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB, handshakes
// with the instruction and data memories, and drives the PC/IR/regfile/memory
// enables. Outputs are decoded from the state register plus opcode/funct3/ready.
//
// Optional feature: define MEM_TIMEOUT_EN to build a wait counter that traps a
// memory request left unanswered for TIMEOUT cycles. Without it the sequencer
// waits indefinitely and only an illegal opcode can trap.
module multicycle_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             EQ,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic [1:0]       pc_sel,
    output logic             ResultSrc,
    output logic [2:0]       state_o,
    output logic             retired,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int NUM_OPS = 9;
    localparam logic [NUM_OPS-1:0][6:0] LEGAL_OPS = {
        OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    };

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   retire_cnt_reg;

    // Raw (pre-reset-gating) control outputs from the decode process
    logic               imem_req_c;
    logic               dmem_req_c;
    logic               mem_write_c;
    logic               ir_write_c;
    logic               reg_write_c;
    logic               pc_write_c;
    logic [1:0]         pc_sel_c;
    logic               result_src_c;

    // Opcode classification
    logic [NUM_OPS-1:0] legal_hit;
    logic               is_legal;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_jal;
    logic               is_jalr;
    logic               branch_taken;
    logic               wait_expire;

    // One comparator per legal opcode; any hit makes the instruction legal
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi = gi + 1) begin : g_legal
            assign legal_hit[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign is_legal  = |legal_hit;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);

    // BEQ takes on equal, BNE on not-equal; other branch funct3 are not-taken
    assign branch_taken = ((funct3 == 3'b000) &&  EQ) ||
                          ((funct3 == 3'b001) && !EQ);

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_reg;
    logic            waiting;

    // A cycle spent with a request outstanding and no ready
    assign waiting = (imem_req_c && !imem_ready) || (dmem_req_c && !dmem_ready);

    // Expires when this waiting cycle would bring the count up to TIMEOUT;
    // ready in that cycle takes priority because waiting is then false.
    assign wait_expire = waiting && (wait_cnt_reg >= TO_W'(TIMEOUT - 1));

    // Wait counter: cleared on any state change, counts stalled request cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            wait_cnt_reg <= '0;
        end else if (waiting) begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
        end
    end
`else
    assign wait_expire = 1'b0;
`endif

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_FETCH;
            retire_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pc_write_c) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next   = state_reg;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        pc_write_c   = 1'b0;
        pc_sel_c     = 2'd0;
        result_src_c = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expire) begin
                    state_next = S_TRAP;
                end
            end

            S_DECODE: begin
                state_next = is_legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_branch) begin
                    pc_write_c = 1'b1;
                    pc_sel_c   = branch_taken ? 2'd1 : 2'd0;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WB;
                end
            end

            S_MEM: begin
                dmem_req_c  = 1'b1;
                mem_write_c = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_write_c = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_expire) begin
                    state_next = S_TRAP;
                end
            end

            S_WB: begin
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                result_src_c = is_load;
                if (is_jal) begin
                    pc_sel_c = 2'd1;
                end else if (is_jalr) begin
                    pc_sel_c = 2'd2;
                end
                state_next = S_FETCH;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            // Unused encodings are treated as a fault
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    // Every output reads zero while reset is being sampled low
    assign imem_req   = rst_n & imem_req_c;
    assign dmem_req   = rst_n & dmem_req_c;
    assign MemWrite   = rst_n & mem_write_c;
    assign IRWrite    = rst_n & ir_write_c;
    assign RegWrite   = rst_n & reg_write_c;
    assign PCWrite    = rst_n & pc_write_c;
    assign pc_sel     = rst_n ? pc_sel_c : 2'd0;
    assign ResultSrc  = rst_n & result_src_c;
    assign state_o    = rst_n ? 3'(state_reg) : 3'd0;
    assign retired    = rst_n & pc_write_c;
    assign retire_cnt = rst_n ? retire_cnt_reg : '0;
    assign trap       = rst_n & (state_reg == S_TRAP);

endmodule
